// File: rtl/parc_rob_ctrl.sv
// Reorder-buffer controller: in-order slot allocation, out-of-order fill, in-order commit,
// plus a youngest-writer lookup per decode source operand.
module parc_rob_ctrl #(
    parameter int NUM_ENTRIES = 16,
    parameter int SLOT_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 alloc_val,
    output logic                 alloc_rdy,
    input  logic                 alloc_wen,
    input  logic [4:0]           alloc_waddr,
    output logic [SLOT_BITS-1:0] alloc_slot,

    input  logic                 fill_val,
    input  logic [SLOT_BITS-1:0] fill_slot,

    output logic                 commit_val,
    output logic                 commit_wen,
    output logic [SLOT_BITS-1:0] commit_slot,
    output logic [4:0]           commit_waddr,

    input  logic [4:0]           src0_addr,
    input  logic [4:0]           src1_addr,
    output logic                 src0_hit,
    output logic                 src1_hit,
    output logic [SLOT_BITS-1:0] src0_slot,
    output logic [SLOT_BITS-1:0] src1_slot,
    output logic                 src0_pending,
    output logic                 src1_pending,

    output logic                 empty,
    output logic [SLOT_BITS:0]   count
);

    localparam logic [SLOT_BITS:0] FULL_COUNT = (SLOT_BITS+1)'(NUM_ENTRIES);

    typedef struct packed {
        logic                 hit;
        logic [SLOT_BITS-1:0] slot;
        logic                 pending;
    } lookup_t;

    logic [NUM_ENTRIES-1:0] ent_valid;
    logic [NUM_ENTRIES-1:0] ent_pending;
    logic [NUM_ENTRIES-1:0] ent_wen;
    logic [4:0]             ent_waddr [NUM_ENTRIES];

    logic [SLOT_BITS-1:0]   head;
    logic [SLOT_BITS-1:0]   tail;

    logic                   alloc_fire;
    lookup_t                src0_res;
    lookup_t                src1_res;

    // Everything handshake-related is decoded from registered state only.
    assign alloc_rdy    = (count != FULL_COUNT);
    assign alloc_fire   = alloc_val && alloc_rdy;
    assign alloc_slot   = tail;

    assign commit_val   = ent_valid[head] && !ent_pending[head];
    assign commit_wen   = commit_val && ent_wen[head] && (ent_waddr[head] != 5'd0);
    assign commit_slot  = head;
    assign commit_waddr = ent_waddr[head];

    assign empty        = (count == '0);

    // Valid entries form a contiguous run from head; scanning oldest to youngest and
    // keeping the last match yields the youngest writer, including when head > tail.
    function automatic lookup_t find_youngest(input logic [4:0] addr);
        lookup_t              res;
        logic [SLOT_BITS-1:0] idx;
        res = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            idx = head + SLOT_BITS'(i);
            if (addr != 5'd0 && ent_valid[idx] && ent_wen[idx] && ent_waddr[idx] == addr) begin
                res.hit     = 1'b1;
                res.slot    = idx;
                res.pending = ent_pending[idx];
            end
        end
        return res;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
    always_comb begin
        src0_res     = find_youngest(src0_addr);
        src1_res     = find_youngest(src1_addr);
        src0_hit     = src0_res.hit;
        src0_slot    = src0_res.slot;
        src0_pending = src0_res.pending;
        src1_hit     = src1_res.hit;
        src1_slot    = src1_res.slot;
        src1_pending = src1_res.pending;
    end

    // NOTE: state registers use non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            if (alloc_fire) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + 1'b1;
            end
            if (commit_val) begin
                ent_valid[head] <= 1'b0;
                head            <= head + 1'b1;
            end
            count <= count + (SLOT_BITS+1)'(alloc_fire) - (SLOT_BITS+1)'(commit_val);
        end
    end

    // NOTE: the payload array is not reset; valid gates every use of it, so stale
    // contents after reset are never observed and the array stays a plain register file.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            ent_pending[tail] <= 1'b1;
            ent_wen[tail]     <= alloc_wen;
            ent_waddr[tail]   <= alloc_waddr;
        end
        if (fill_val && ent_valid[fill_slot]) begin
            ent_pending[fill_slot] <= 1'b0;
        end
    end

    // Writeback must only target a slot that is currently in flight.
    fill_of_invalid_slot: assert property (
        @(posedge clk) disable iff (reset) fill_val |-> ent_valid[fill_slot]
    );

endmodule

// File: tb/tb_parc_rob_ctrl.sv
// Self-checking bench for parc_rob_ctrl: directed scenarios plus a randomized phase,
// all compared against an in-order queue model of the reorder buffer.
module tb_parc_rob_ctrl;

    localparam int N = 16;

    logic       clk;
    logic       reset;
    logic       alloc_val;
    logic       alloc_rdy;
    logic       alloc_wen;
    logic [4:0] alloc_waddr;
    logic [3:0] alloc_slot;
    logic       fill_val;
    logic [3:0] fill_slot;
    logic       commit_val;
    logic       commit_wen;
    logic [3:0] commit_slot;
    logic [4:0] commit_waddr;
    logic [4:0] src0_addr;
    logic [4:0] src1_addr;
    logic       src0_hit;
    logic       src1_hit;
    logic [3:0] src0_slot;
    logic [3:0] src1_slot;
    logic       src0_pending;
    logic       src1_pending;
    logic       empty;
    logic [4:0] count;

    int checks   = 0;
    int failures = 0;

    parc_rob_ctrl #(.NUM_ENTRIES(16), .SLOT_BITS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .alloc_val    (alloc_val),
        .alloc_rdy    (alloc_rdy),
        .alloc_wen    (alloc_wen),
        .alloc_waddr  (alloc_waddr),
        .alloc_slot   (alloc_slot),
        .fill_val     (fill_val),
        .fill_slot    (fill_slot),
        .commit_val   (commit_val),
        .commit_wen   (commit_wen),
        .commit_slot  (commit_slot),
        .commit_waddr (commit_waddr),
        .src0_addr    (src0_addr),
        .src1_addr    (src1_addr),
        .src0_hit     (src0_hit),
        .src1_hit     (src1_hit),
        .src0_slot    (src0_slot),
        .src1_slot    (src1_slot),
        .src0_pending (src0_pending),
        .src1_pending (src1_pending),
        .empty        (empty),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Reference model: in-flight instructions in program order, oldest first.
    typedef struct {
        int slot;
        bit wen;
        int waddr;
        bit pending;
    } ent_t;

    ent_t rob[$];
    int   mhead = 0;
    int   mtail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_lookup(input int addr, output bit hit, output int slot, output bit pend);
        hit  = 1'b0;
        slot = 0;
        pend = 1'b0;
        if (addr != 0) begin
            foreach (rob[i]) begin
                if (rob[i].wen && rob[i].waddr == addr) begin
                    hit  = 1'b1;
                    slot = rob[i].slot;
                    pend = rob[i].pending;
                end
            end
        end
    endfunction

    task automatic set_idle();
        reset       = 1'b0;
        alloc_val   = 1'b0;
        alloc_wen   = 1'b0;
        alloc_waddr = 5'd0;
        fill_val    = 1'b0;
        fill_slot   = 4'd0;
        src0_addr   = 5'd0;
        src1_addr   = 5'd0;
    endtask

    task automatic settle();
        #1;
    endtask

    // Compare every output against the model, advance the model with the applied
    // inputs, then cross one clock edge.
    task automatic run_cycle();
        int n;
        bit e_cv;
        bit e_cw;
        bit h0, h1, p0, p1;
        int s0, s1;
        bit fire;
        #1;
        n    = rob.size();
        e_cv = 1'b0;
        e_cw = 1'b0;
        if (n > 0) begin
            e_cv = !rob[0].pending;
            e_cw = e_cv && rob[0].wen && rob[0].waddr != 0;
        end
        model_lookup(int'(src0_addr), h0, s0, p0);
        model_lookup(int'(src1_addr), h1, s1, p1);
        check("count",       32'(count),       n);
        check("empty",       32'(empty),       (n == 0));
        check("alloc_rdy",   32'(alloc_rdy),   (n != N));
        check("alloc_slot",  32'(alloc_slot),  mtail);
        check("commit_val",  32'(commit_val),  e_cv);
        check("commit_wen",  32'(commit_wen),  e_cw);
        check("commit_slot", 32'(commit_slot), mhead);
        if (e_cv) check("commit_waddr", 32'(commit_waddr), rob[0].waddr);
        check("src0_hit",     32'(src0_hit),     h0);
        check("src0_slot",    32'(src0_slot),    s0);
        check("src0_pending", 32'(src0_pending), p0);
        check("src1_hit",     32'(src1_hit),     h1);
        check("src1_slot",    32'(src1_slot),    s1);
        check("src1_pending", 32'(src1_pending), p1);

        fire = alloc_val && (n != N);
        if (reset) begin
            rob.delete();
            mhead = 0;
            mtail = 0;
        end else begin
            if (fill_val) begin
                foreach (rob[i]) if (rob[i].slot == int'(fill_slot)) rob[i].pending = 1'b0;
            end
            if (e_cv) begin
                void'(rob.pop_front());
                mhead = (mhead + 1) % N;
            end
            if (fire) begin
                rob.push_back('{slot: mtail, wen: alloc_wen, waddr: int'(alloc_waddr), pending: 1'b1});
                mtail = (mtail + 1) % N;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic alloc_one(input bit wen, input int waddr);
        set_idle();
        alloc_val   = 1'b1;
        alloc_wen   = wen;
        alloc_waddr = 5'(waddr);
        run_cycle();
    endtask

    task automatic fill_one(input int slot);
        set_idle();
        fill_val  = 1'b1;
        fill_slot = 4'(slot);
        run_cycle();
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1'b1;
        run_cycle();
        reset = 1'b0;
    endtask

    initial begin
        set_idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        settle();
        check("rst_alloc_rdy",  32'(alloc_rdy),  1);
        check("rst_alloc_slot", 32'(alloc_slot), 0);
        check("rst_commit_val", 32'(commit_val), 0);
        check("rst_commit_wen", 32'(commit_wen), 0);
        check("rst_src0_hit",   32'(src0_hit),   0);
        check("rst_src1_hit",   32'(src1_hit),   0);
        check("rst_empty",      32'(empty),      1);
        check("rst_count",      32'(count),      0);

        // Three writers r5, r6, r7.
        for (int i = 0; i < 3; i++) begin
            set_idle();
            alloc_val   = 1'b1;
            alloc_wen   = 1'b1;
            alloc_waddr = 5'(5 + i);
            settle();
            check("alloc_seq_slot", 32'(alloc_slot), i);
            run_cycle();
        end
        set_idle();
        settle();
        check("three_count",      32'(count),      3);
        check("three_commit_val", 32'(commit_val), 0);

        // Out-of-order fill: head stays blocked until slot 0 fills.
        fill_one(1);
        set_idle();
        settle();
        check("head_blocked", 32'(commit_val), 0);
        fill_one(0);
        set_idle();
        settle();
        check("c0_val",   32'(commit_val),   1);
        check("c0_slot",  32'(commit_slot),  0);
        check("c0_waddr", 32'(commit_waddr), 5);
        check("c0_wen",   32'(commit_wen),   1);
        run_cycle();
        settle();
        check("c1_val",   32'(commit_val),   1);
        check("c1_slot",  32'(commit_slot),  1);
        check("c1_waddr", 32'(commit_waddr), 6);
        check("c1_wen",   32'(commit_wen),   1);
        run_cycle();
        settle();
        check("c2_blocked", 32'(commit_val), 0);
        fill_one(2);
        set_idle();
        run_cycle();

        // Fill the buffer, then free one slot while allocation is held.
        do_reset();
        for (int i = 0; i < N; i++) alloc_one(1'b1, i + 1);
        set_idle();
        alloc_val   = 1'b1;
        alloc_wen   = 1'b1;
        alloc_waddr = 5'd20;
        settle();
        check("full_rdy",   32'(alloc_rdy), 0);
        check("full_count", 32'(count),     16);
        fill_val  = 1'b1;
        fill_slot = 4'd0;
        run_cycle();
        fill_val = 1'b0;
        settle();
        check("full_commit_val", 32'(commit_val), 1);
        check("full_still_busy", 32'(alloc_rdy),  0);
        run_cycle();
        settle();
        check("freed_rdy",   32'(alloc_rdy),  1);
        check("wrap_slot",   32'(alloc_slot), 0);
        check("freed_count", 32'(count),      15);
        run_cycle();
        for (int i = 1; i <= N; i++) fill_one(i % N);
        set_idle();
        repeat (2) run_cycle();
        settle();
        check("drained_empty", 32'(empty), 1);

        // Two r9 writers straddling the wrap point.
        do_reset();
        for (int i = 0; i < 14; i++) alloc_one(1'b0, 0);
        for (int i = 0; i < 14; i++) fill_one(i);
        set_idle();
        repeat (2) run_cycle();
        alloc_one(1'b1, 9);
        alloc_one(1'b1, 3);
        alloc_one(1'b1, 4);
        alloc_one(1'b1, 9);
        fill_one(14);
        set_idle();
        src0_addr = 5'd9;
        src1_addr = 5'd9;
        settle();
        check("r9_hit0",  32'(src0_hit),     1);
        check("r9_slot0", 32'(src0_slot),    1);
        check("r9_pend0", 32'(src0_pending), 1);
        check("r9_slot1", 32'(src1_slot),    1);
        run_cycle();
        fill_one(15);
        fill_one(0);
        fill_one(1);
        set_idle();
        repeat (2) run_cycle();
        src0_addr = 5'd9;
        settle();
        check("r9_gone_hit",  32'(src0_hit),     0);
        check("r9_gone_slot", 32'(src0_slot),    0);
        check("r9_gone_pend", 32'(src0_pending), 0);
        run_cycle();

        // r0 destination and a store both retire without a register write.
        alloc_one(1'b1, 0);
        alloc_one(1'b0, 12);
        set_idle();
        src0_addr = 5'd0;
        src1_addr = 5'd12;
        settle();
        check("r0_hit",    32'(src0_hit), 0);
        check("store_hit", 32'(src1_hit), 0);
        run_cycle();
        fill_one(2);
        set_idle();
        settle();
        check("r0_commit_val", 32'(commit_val), 1);
        check("r0_commit_wen", 32'(commit_wen), 0);
        fill_val  = 1'b1;
        fill_slot = 4'd3;
        run_cycle();
        set_idle();
        settle();
        check("st_commit_val", 32'(commit_val), 1);
        check("st_commit_wen", 32'(commit_wen), 0);
        run_cycle();

        // Randomized traffic: a fill-starved phase then a fill-heavy phase.
        for (int k = 0; k < 700; k++) begin
            int fill_pct;
            fill_pct = (k < 350) ? 30 : 85;
            set_idle();
            reset       = ($urandom_range(99) == 0);
            alloc_val   = ($urandom_range(3) != 0);
            alloc_wen   = ($urandom_range(4) != 0);
            alloc_waddr = 5'($urandom_range(7));
            src0_addr   = 5'($urandom_range(7));
            src1_addr   = 5'($urandom_range(7));
            if (rob.size() > 0 && $urandom_range(99) < fill_pct) begin
                fill_val  = 1'b1;
                fill_slot = 4'(rob[$urandom_range(rob.size() - 1)].slot);
            end
            run_cycle();
        end

        // Reset with five entries in flight discards them all.
        do_reset();
        for (int i = 0; i < 5; i++) alloc_one(1'b1, i + 1);
        fill_one(2);
        set_idle();
        reset     = 1'b1;
        src0_addr = 5'd1;
        src1_addr = 5'd2;
        run_cycle();
        set_idle();
        src0_addr = 5'd1;
        src1_addr = 5'd2;
        settle();
        check("mid_rst_count",  32'(count),      0);
        check("mid_rst_empty",  32'(empty),      1);
        check("mid_rst_commit", 32'(commit_val), 0);
        check("mid_rst_hit0",   32'(src0_hit),   0);
        check("mid_rst_hit1",   32'(src1_hit),   0);
        check("mid_rst_slot",   32'(alloc_slot), 0);
        run_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
